// File: rtl/serial_pkg.sv
// Shared definitions for the serial console device: FSM encodings and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_FIFO_DEPTH   = 4;

  // Both UART directions walk the same four phases of an 8N1 frame.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with wrap-bit pointers; head is presented combinationally (0 when empty).
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push while full is ignored unless a pop in the same cycle frees the slot.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Equal indices: the wrap bit tells full (differs) from empty (matches).
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the queue without touching storage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/serial_console_device.sv
// CPU-facing byte port bridged to an 8N1 UART through TX and RX FIFOs, with sticky error flags.
// Latency: TX line drops 1 cycle after a byte is stored; RX byte lands 4+CLKS_PER_BIT/2+9*CLKS_PER_BIT cycles after start edge.
// Backpressure: serial_ready_out low when TX FIFO full (writes then dropped); RX bytes dropped when RX FIFO full.
module serial_console_device
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] serial_data_in,
  input  logic       serial_wren_in,
  input  logic       serial_rden_in,
  output logic [7:0] serial_data_out,
  output logic       serial_ready_out,
  output logic       serial_valid_out,
  output logic       uart_tx_out,
  input  logic       uart_rx_in,
  output logic       tx_overflow_out,
  output logic       rx_overflow_out,
  output logic       frame_err_out
);

  localparam int          CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // TX side
  uart_state_t tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic [7:0]  tx_head;
  logic        tx_full, tx_empty, tx_pop, tx_last, tx_drop;

  // RX side
  uart_state_t rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic [1:0]  rx_sync;
  logic        rx_prev, rx_s, rx_push, rx_full, rx_empty, rx_drop;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (serial_wren_in),
    .push_data (serial_data_in),
    .pop       (tx_pop),
    .head_data (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (serial_rden_in),
    .head_data (serial_data_out),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign serial_ready_out = !tx_full;
  assign serial_valid_out = !rx_empty;
  assign tx_last = (tx_cnt == BIT_LAST);
  // Pop from idle, or at the very end of a stop bit so frames run back-to-back.
  assign tx_pop  = !tx_empty && ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_last));
  // A full FIFO accepts only when the same cycle pops (TX pop / RX rden both need non-empty, implied by full).
  assign tx_drop = serial_wren_in && tx_full && !tx_pop;
  assign rx_drop = rx_push && rx_full && !serial_rden_in;
  assign rx_s    = rx_sync[1];

  // TX frame generator; uart_tx_out is a register so the line never glitches.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state    <= ST_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      uart_tx_out <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_state    <= ST_START;
            tx_cnt      <= '0;
            tx_shift    <= tx_head;
            uart_tx_out <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_last) begin
            tx_state    <= ST_DATA;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            uart_tx_out <= tx_shift[0];
            tx_shift    <= tx_shift >> 1;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state    <= ST_STOP;
              uart_tx_out <= 1'b1;
            end else begin
              tx_bit      <= tx_bit + 3'd1;
              uart_tx_out <= tx_shift[0];
              tx_shift    <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_state    <= ST_START;
              tx_shift    <= tx_head;
              uart_tx_out <= 1'b0;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle-high reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx_in};
      rx_prev <= rx_s;
    end
  end

  // RX frame sampler: mid-start check rejects glitches, then one sample per bit period.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state      <= ST_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_push       <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= ST_START;
            rx_cnt   <= '0;
          end
        end
        ST_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= ST_IDLE;
            if (rx_s) rx_push       <= 1'b1;
            else      frame_err_out <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_overflow_out <= 1'b0;
      rx_overflow_out <= 1'b0;
    end else begin
      if (tx_drop) tx_overflow_out <= 1'b1;
      if (rx_drop) rx_overflow_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_console_device.sv
// Randomized + directed bench for serial_console_device with queue scoreboards and line-level monitors.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_console_device;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Receiver delivery point relative to the start-bit launch edge:
  // 2 sync flops + edge detect + start half-bit + 8 data bits + stop bit + push register.
  localparam int RX_PUSH_AT = 4 + CPB / 2 + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] serial_data_in;
  logic       serial_wren_in;
  logic       serial_rden_in;
  logic [7:0] serial_data_out;
  logic       serial_ready_out;
  logic       serial_valid_out;
  logic       uart_tx_out;
  logic       uart_rx_in;
  logic       tx_overflow_out;
  logic       rx_overflow_out;
  logic       frame_err_out;

  serial_console_device #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .serial_data_in   (serial_data_in),
    .serial_wren_in   (serial_wren_in),
    .serial_rden_in   (serial_rden_in),
    .serial_data_out  (serial_data_out),
    .serial_ready_out (serial_ready_out),
    .serial_valid_out (serial_valid_out),
    .uart_tx_out      (uart_tx_out),
    .uart_rx_in       (uart_rx_in),
    .tx_overflow_out  (tx_overflow_out),
    .rx_overflow_out  (rx_overflow_out),
    .frame_err_out    (frame_err_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int         tx_starts[$];
  logic exp_tx_ovf, exp_rx_ovf, exp_ferr;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ideal line level n cycles after the write edge for a single frame of byte b.
  function automatic logic exp_line(input logic [7:0] b, input int n);
    logic [7:0] s;
    if (n >= 1 && n <= CPB) return 1'b0;
    if (n > CPB && n <= 9 * CPB) begin
      s = b >> ((n - CPB - 1) / CPB);
      return s[0];
    end
    return 1'b1;
  endfunction

  task automatic check_flags(input string tag);
    check({tag, "_tx_ovf"}, tx_overflow_out, exp_tx_ovf);
    check({tag, "_rx_ovf"}, rx_overflow_out, exp_rx_ovf);
    check({tag, "_frame_err"}, frame_err_out, exp_ferr);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    serial_wren_in = 1'b0;
    serial_rden_in = 1'b0;
    uart_rx_in = 1'b1;
    tick();
    tx_exp.delete();
    rx_exp.delete();
    exp_tx_ovf = 1'b0;
    exp_rx_ovf = 1'b0;
    exp_ferr   = 1'b0;
    check("rst_tx_line", uart_tx_out, 1);
    check("rst_ready", serial_ready_out, 1);
    check("rst_valid", serial_valid_out, 0);
    check("rst_data", serial_data_out, 0);
    check_flags("rst");
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    serial_data_in = b;
    serial_wren_in = 1'b1;
    tick();
    serial_wren_in = 1'b0;
  endtask

  task automatic read_pulse();
    serial_rden_in = 1'b1;
    tick();
    serial_rden_in = 1'b0;
  endtask

  // Cycle-exact check of one isolated frame on the TX line.
  task automatic tx_frame_exact(input logic [7:0] b);
    tx_exp.push_back(b);
    write_byte(b);
    for (int n = 1; n <= 10 * CPB + 3; n++) begin
      tick();
      check("tx_line_exact", uart_tx_out, exp_line(b, n));
    end
  endtask

  // Drive one 8N1 frame; optionally pop the RX head in the cycle the byte lands.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_push);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int n = 0; n < 10 * CPB; n++) begin
      uart_rx_in = bits[0];
      if (pop_at_push) begin
        if (n == RX_PUSH_AT - 1)  serial_rden_in = 1'b1;
        else if (n == RX_PUSH_AT) serial_rden_in = 1'b0;
      end
      if (n % CPB == CPB - 1) bits = bits >> 1;
      tick();
    end
    uart_rx_in = 1'b1;
    if (stop) begin
      if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
      else                       exp_rx_ovf = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  task automatic glitch(input int w);
    uart_rx_in = 1'b0;
    repeat (w) tick();
    uart_rx_in = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  task automatic drain_rx();
    for (int k = 0; k < 2 * DEPTH && serial_valid_out; k++) read_pulse();
  endtask

  task automatic wait_tx_drain(input int budget);
    for (int k = 0; k < budget && (tx_exp.size() != 0 || uart_tx_out == 1'b0); k++) tick();
    check("tx_drain_left", tx_exp.size(), 0);
  endtask

  // TX monitor: decode frames at mid-bit and compare with the expected byte queue.
  initial begin : tx_mon
    logic [7:0] d;
    logic       st_ok, sp;
    bit         aborted;
    int         start;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && uart_tx_out === 1'b0) begin
        start = cyc;
        aborted = 0;
        d = '0;
        st_ok = 1'b0;
        sp = 1'b0;
        for (int k = 1; k <= 9 * CPB + CPB / 2 && !aborted; k++) begin
          @(negedge clock);
          if (reset !== 1'b1) aborted = 1;
          else if (k == CPB / 2) st_ok = !uart_tx_out;
          else if (k > CPB / 2 && k < 9 * CPB && (k - CPB / 2) % CPB == 0) d = {uart_tx_out, d[7:1]};
          else if (k == 9 * CPB + CPB / 2) sp = uart_tx_out;
        end
        if (!aborted) begin
          tx_starts.push_back(start);
          check("tx_start_bit", st_ok, 1);
          check("tx_stop_bit", sp, 1);
          if (tx_exp.size() == 0) check("tx_unexpected_frame", d, -1);
          else check("tx_byte", d, tx_exp.pop_front());
        end
      end
    end
  end

  // RX monitor: every accepted pop must return the oldest expected byte.
  initial begin : rx_mon
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && serial_rden_in === 1'b1 && serial_valid_out === 1'b1) begin
        if (rx_exp.size() == 0) check("rx_unexpected_byte", serial_data_out, -1);
        else check("rx_byte", serial_data_out, rx_exp.pop_front());
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin : main
    reset = 1'b0;
    serial_data_in = '0;
    serial_wren_in = 1'b0;
    serial_rden_in = 1'b0;
    uart_rx_in = 1'b1;
    exp_tx_ovf = 1'b0;
    exp_rx_ovf = 1'b0;
    exp_ferr   = 1'b0;
    tick();
    apply_reset();

    // Single byte, cycle-exact line shape.
    tx_frame_exact(8'h41);
    check("tx_exp_empty_41", tx_exp.size(), 0);

    // Fill TX FIFO behind an in-flight byte, fifth write overflows.
    tx_starts.delete();
    tx_exp.push_back(8'hAA);
    write_byte(8'hAA);
    tick();
    check("ready_before_burst", serial_ready_out, 1);
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) tx_exp.push_back(8'(i));
      else exp_tx_ovf = 1'b1;
      write_byte(8'(i));
      if (i == DEPTH) check("ready_after_fourth", serial_ready_out, 0);
    end
    check("ready_after_fifth", serial_ready_out, 0);
    check_flags("burst");
    wait_tx_drain(8 * 10 * CPB);
    check("burst_frame_count", tx_starts.size(), 5);
    for (int i = 1; i < tx_starts.size(); i++)
      check("burst_contiguous", tx_starts[i] - tx_starts[i-1], 10 * CPB);
    check_flags("burst_sticky");
    apply_reset();

    // Clean RX frame then pop.
    send_frame(8'hA5, 1'b1, 1'b0);
    tick();
    check("rx_valid_a5", serial_valid_out, 1);
    check("rx_data_a5", serial_data_out, 8'hA5);
    read_pulse();
    check("rx_valid_after_pop", serial_valid_out, 0);
    check("rx_data_after_pop", serial_data_out, 0);

    // Bad stop bit: discarded, frame error.
    repeat (4) tick();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (4) tick();
    check("ferr_valid", serial_valid_out, 0);
    check_flags("ferr");
    apply_reset();

    // Short low glitch: rejected, no flag; receiver still works afterwards.
    glitch(4);
    repeat (10 * CPB) tick();
    check("glitch_valid", serial_valid_out, 0);
    check_flags("glitch");
    send_frame(8'h96, 1'b1, 1'b0);
    tick();
    check("post_glitch_valid", serial_valid_out, 1);
    drain_rx();

    // RX full: same-cycle pop makes room, otherwise overflow.
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    tick();
    check("rx_full_valid", serial_valid_out, 1);
    send_frame(8'hE1, 1'b1, 1'b1);
    tick();
    check("rx_pop_push_ovf", rx_overflow_out, 0);
    check("rx_pop_push_count", rx_exp.size(), DEPTH);
    send_frame(8'hE2, 1'b1, 1'b0);
    tick();
    check_flags("rx_overflow");
    drain_rx();
    check("rx_drained_valid", serial_valid_out, 0);
    check("rx_exp_left", rx_exp.size(), 0);
    check_flags("rx_overflow_sticky");
    apply_reset();

    // Reset in the middle of bit 3 aborts the frame and empties the queued byte.
    tx_exp.push_back(8'h5A);
    write_byte(8'h5A);
    write_byte(8'h77);
    repeat (68) tick();
    check("mid_frame_bit3", uart_tx_out, exp_line(8'h5A, 70));
    apply_reset();
    tx_frame_exact(8'hC3);
    repeat (3 * CPB) tick();
    check("post_abort_exp_empty", tx_exp.size(), 0);

    // Randomized full-duplex traffic.
    fork
      begin : rand_tx
        for (int i = 0; i < 20; i++) begin
          logic [7:0] b;
          int w;
          b = 8'($urandom);
          w = 0;
          while (!serial_ready_out && w < 40 * CPB) begin tick(); w++; end
          check("rand_tx_ready_timeout", serial_ready_out, 1);
          tx_exp.push_back(b);
          write_byte(b);
          repeat ($urandom_range(0, 200)) tick();
        end
      end
      begin : rand_rx
        for (int i = 0; i < 14; i++) begin
          int r;
          r = $urandom_range(0, 9);
          if (r == 0) glitch($urandom_range(1, 4));
          else send_frame(8'($urandom), (r != 1), 1'b0);
          repeat ($urandom_range(4, 20)) tick();
          drain_rx();
        end
      end
    join
    wait_tx_drain(30 * 10 * CPB);
    check("rand_rx_exp_left", rx_exp.size(), 0);
    check_flags("rand_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_console_device.md
SERIAL_CONSOLE_DEVICE -- requirements
Module: serial_console_device

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clocks per UART bit period (even, >=4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per TX and RX FIFO (power of 2).
REQ-003 SHALL have port clock  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port serial_data_in  input  8  byte written by the CPU side (the memory's serial_out).
REQ-006 SHALL have port serial_wren_in  input  1  push serial_data_in into TX FIFO.
REQ-007 SHALL have port serial_rden_in  input  1  pop the RX FIFO head.
REQ-008 SHALL have port serial_data_out  output  8  RX FIFO head byte (the memory's serial_in).
REQ-009 SHALL have port serial_ready_out  output  1  TX FIFO not full.
REQ-010 SHALL have port serial_valid_out  output  1  RX FIFO not empty.
REQ-011 SHALL have port uart_tx_out  output  1  8N1 line, idle high.
REQ-012 SHALL have port uart_rx_in  input  1  8N1 line, asynchronous.
REQ-013 SHALL have port tx_overflow_out  output  1  sticky: write dropped while full.
REQ-014 SHALL have port rx_overflow_out  output  1  sticky: received byte dropped while RX full.
REQ-015 SHALL have port frame_err_out  output  1  sticky: stop bit sampled low.

Function
REQ-016 SHALL, on serial_wren_in with TX not full, store the byte at the next edge; when full, drop it and set tx_overflow_out.
REQ-017 SHALL drive serial_data_out combinationally from the RX head; value undefined-free (0x00) when empty.
REQ-018 SHALL, on serial_rden_in with RX non-empty, pop at the next edge; rden on empty is ignored.
REQ-019 SHALL allow simultaneous push and pop on the same FIFO in one cycle, count unchanged, including when full (pop frees a slot) and empty (push-only applies).
REQ-020 SHALL implement FIFO pointers modulo FIFO_DEPTH, with an extra wrap bit distinguishing full from empty.
REQ-021 SHALL implement TX FSM IDLE -> START -> DATA -> STOP -> IDLE; each state after IDLE holds for CLKS_PER_BIT cycles per bit.
REQ-022 SHALL, in IDLE with TX non-empty, pop one byte and drive uart_tx_out low starting the next cycle.
REQ-023 SHALL send DATA LSB first, 8 bits; STOP drives 1 for one bit period; back-to-back bytes SHALL have no extra idle gap.
REQ-024 SHALL pass uart_rx_in through a 2-flop synchronizer, reset value 1.
REQ-025 SHALL implement RX FSM IDLE -> START -> DATA -> STOP -> IDLE; IDLE leaves on a synchronized falling edge.
REQ-026 SHALL re-sample at CLKS_PER_BIT/2 in START; if high, return to IDLE (glitch rejection) with no flag set.
REQ-027 SHALL sample each data bit and the stop bit one CLKS_PER_BIT after the previous sample (mid-bit).
REQ-028 SHALL, on stop bit = 1, push the byte (or drop it and set rx_overflow_out if full); on stop bit = 0, discard it and set frame_err_out.
REQ-029 SHALL keep sticky flags set until reset.

Reset
REQ-030 SHALL, when reset is low at a rising edge, empty both FIFOs, put both FSMs in IDLE, and clear all counters and flags.
REQ-031 SHALL drive, during/after reset: uart_tx_out=1, serial_ready_out=1, serial_valid_out=0, serial_data_out=0x00, all flags=0.
REQ-032 SHALL abort an in-flight TX frame on reset mid-frame (line returns high next cycle; the byte is lost).

Structure
REQ-033 SHALL place FSM state encodings and default CLKS_PER_BIT/FIFO_DEPTH in shared package serial_pkg.
REQ-034 SHALL instantiate one sub-module, sync_fifo (8-bit, parameterised depth), twice for TX and RX.

Verification
REQ-035 Write 0x41 -> uart_tx_out low at cycle 1 for 16 cycles, bits 1,0,0,0,0,0,1,0, then high; frame = 160 cycles.
REQ-036 Five writes 0x01..0x05 back-to-back with the line busy -> serial_ready_out=0 after the fourth stored byte, fifth dropped, tx_overflow_out=1; 0x01..0x04 transmitted contiguously.
REQ-037 Drive 8N1 frame 0xA5 on uart_rx_in -> serial_valid_out=1, serial_data_out=0xA5; rden -> valid=0 next cycle.
REQ-038 Frame 0x3C with stop bit 0 -> no push, frame_err_out=1; a 4-cycle low glitch -> no push, no flag.
REQ-039 RX full (4 bytes), fifth frame arrives while rden pops in the same cycle as the push -> byte stored, no overflow; without the pop -> rx_overflow_out=1.
REQ-040 Assert reset at bit 3 of a TX frame -> uart_tx_out=1 next cycle, FIFOs empty, flags 0, next write starts a clean frame.
